// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops with per-bit JK, parallel load, up/down count and shift-left modes.
// Optional macro JK_BANK_SAT_EN: COUNT saturates at the limits and tc is level-high while saturated.
module jk_reg_bank #(
    parameter int unsigned           WIDTH   = 8,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             tc
);

    localparam logic [1:0]       MODE_JK    = 2'b00;
    localparam logic [1:0]       MODE_LOAD  = 2'b01;
    localparam logic [1:0]       MODE_COUNT = 2'b10;
    localparam logic [1:0]       MODE_SHIFT = 2'b11;
    localparam logic [WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [WIDTH-1:0] ALL_ZEROS  = '0;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qb;
    logic             r_tc;

    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_q_next;
    logic             w_carry;
    logic             w_at_limit;
    logic             w_tc_next;

    // Counter toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        w_t     = '0;
        w_carry = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_t[i]  = w_carry;
            w_carry = w_carry & (dir ? r_q[i] : ~r_q[i]);
        end
    end

    assign w_at_limit = dir ? (r_q == ALL_ONES) : (r_q == ALL_ZEROS);
    assign w_shift    = {r_q[WIDTH-2:0], sin};

    // Every mode is mapped onto per-bit J/K drives feeding one shared JK equation
    always_comb begin
        w_j       = '0;
        w_k       = '0;
        w_tc_next = 1'b0;
        case (mode)
            MODE_JK: begin
                w_j = j;
                w_k = k;
            end
            MODE_LOAD: begin
                w_j = d;
                w_k = ~d;
            end
            MODE_COUNT: begin
`ifdef JK_BANK_SAT_EN
                if (!w_at_limit) begin
                    w_j = w_t;
                    w_k = w_t;
                end
`else
                w_j = w_t;
                w_k = w_t;
`endif
                w_tc_next = w_at_limit;
            end
            MODE_SHIFT: begin
                w_j = w_shift;
                w_k = ~w_shift;
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
        w_q_next = (w_j & ~r_q) | (~w_k & r_q);
    end

    // Q and Qb share one edge so the complement never lags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q  <= RST_VAL;
            r_qb <= ~RST_VAL;
            r_tc <= 1'b0;
        end else if (en) begin
            r_q  <= w_q_next;
            r_qb <= ~w_q_next;
            r_tc <= w_tc_next;
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign Q  = r_q;
    assign Qb = r_qb;
    assign tc = r_tc;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank: directed scenarios plus randomized traffic against a behavioural model.
module tb_jk_reg_bank;

    localparam int unsigned WIDTH   = 8;
    localparam logic [7:0]  RST_VAL = 8'hA5;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] d;
    logic       dir;
    logic       sin;
    logic [7:0] Q;
    logic [7:0] Qb;
    logic       tc;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_q;
    logic       m_tc;

    jk_reg_bank #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .j    (j),
        .k    (k),
        .d    (d),
        .dir  (dir),
        .sin  (sin),
        .Q    (Q),
        .Qb   (Qb),
        .tc   (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what one enabled/disabled edge does to the register, from the mode rules
    function automatic void model_edge();
        logic [7:0] nq;
        if (!en) begin
            m_tc = 1'b0;
            return;
        end
        nq   = m_q;
        m_tc = 1'b0;
        case (mode)
            2'd0: begin
                for (int i = 0; i < 8; i++) begin
                    case ({j[i], k[i]})
                        2'b01:   nq[i] = 1'b0;
                        2'b10:   nq[i] = 1'b1;
                        2'b11:   nq[i] = ~m_q[i];
                        default: nq[i] = m_q[i];
                    endcase
                end
            end
            2'd1: nq = d;
            2'd2: begin
                if (dir) begin
                    m_tc = (m_q == 8'hFF);
`ifdef JK_BANK_SAT_EN
                    nq = m_tc ? m_q : 8'((int'(m_q) + 1) % 256);
`else
                    nq = 8'((int'(m_q) + 1) % 256);
`endif
                end else begin
                    m_tc = (m_q == 8'h00);
`ifdef JK_BANK_SAT_EN
                    nq = m_tc ? m_q : 8'((int'(m_q) + 255) % 256);
`else
                    nq = 8'((int'(m_q) + 255) % 256);
`endif
                end
            end
            default: nq = {m_q[6:0], sin};
        endcase
        m_q = nq;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'd2; dir = 1'b1;
        j = '0; k = '0; d = '0; sin = 1'b0;
        #2;
        total++;
        if (Q !== 8'hA5 || Qb !== 8'h5A || tc !== 1'b0) begin
            bad++;
            $display("FAIL reset_initial Q=%h Qb=%h tc=%b want Q=a5 Qb=5a tc=0", Q, Qb, tc);
        end
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            total++;
            if (Q !== 8'hA5 || Qb !== 8'h5A || tc !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold_count n=%0d Q=%h Qb=%h tc=%b want a5/5a/0", n, Q, Qb, tc);
            end
        end
        rst = 1'b0;
        m_q = RST_VAL; m_tc = 1'b0;
        mode = 2'd1; d = 8'h00;
        tick();
        total++;
        if (Q !== 8'h00 || Qb !== 8'hFF) begin
            bad++;
            $display("FAIL reset_release_load Q=%h Qb=%h want 00/ff", Q, Qb);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (Q !== 8'hA5 || Qb !== 8'h5A || tc !== 1'b0) begin
            bad++;
            $display("FAIL reset_async Q=%h Qb=%h tc=%b want a5/5a/0", Q, Qb, tc);
        end
        @(posedge clk);
        #1;
        total++;
        if (Q !== 8'hA5 || tc !== 1'b0) begin
            bad++;
            $display("FAIL reset_over_load Q=%h tc=%b want a5/0", Q, tc);
        end
        rst = 1'b0;
        m_q = RST_VAL; m_tc = 1'b0;
    endtask

    task automatic test_jk();
        mode = 2'd1; d = 8'h0F;
        tick();
        total++;
        if (Q !== 8'h0F || Qb !== 8'hF0 || tc !== 1'b0) begin
            bad++;
            $display("FAIL jk_preload Q=%h Qb=%h tc=%b want 0f/f0/0", Q, Qb, tc);
        end
        mode = 2'd0; j = 8'hF0; k = 8'h3C;
        tick();
        total++;
        if (Q !== 8'hF3 || Qb !== 8'h0C || tc !== 1'b0) begin
            bad++;
            $display("FAIL jk_mixed Q=%h Qb=%h tc=%b want f3/0c/0", Q, Qb, tc);
        end
    endtask

    task automatic test_count_up();
        logic [7:0] exp_q [3];
        logic       exp_tc[3];
`ifdef JK_BANK_SAT_EN
        exp_q[0] = 8'hFF; exp_q[1] = 8'hFF; exp_q[2] = 8'hFF;
        exp_tc[0] = 1'b0; exp_tc[1] = 1'b1; exp_tc[2] = 1'b1;
`else
        exp_q[0] = 8'hFF; exp_q[1] = 8'h00; exp_q[2] = 8'h01;
        exp_tc[0] = 1'b0; exp_tc[1] = 1'b1; exp_tc[2] = 1'b0;
`endif
        mode = 2'd1; d = 8'hFE;
        tick();
        mode = 2'd2; dir = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if (Q !== exp_q[n] || Qb !== ~exp_q[n] || tc !== exp_tc[n]) begin
                bad++;
                $display("FAIL count_up n=%0d Q=%h Qb=%h tc=%b want Q=%h tc=%b", n, Q, Qb, tc, exp_q[n], exp_tc[n]);
            end
        end
    endtask

    task automatic test_count_down_en_gap();
        logic [7:0] exp_q [2];
        logic       exp_tc[2];
`ifdef JK_BANK_SAT_EN
        exp_q[0] = 8'h00; exp_q[1] = 8'h00;
`else
        exp_q[0] = 8'h00; exp_q[1] = 8'hFF;
`endif
        exp_tc[0] = 1'b0; exp_tc[1] = 1'b1;
        mode = 2'd1; d = 8'h01;
        tick();
        mode = 2'd2; dir = 1'b0;
        for (int n = 0; n < 2; n++) begin
            tick();
            total++;
            if (Q !== exp_q[n] || Qb !== ~exp_q[n] || tc !== exp_tc[n]) begin
                bad++;
                $display("FAIL count_down n=%0d Q=%h Qb=%h tc=%b want Q=%h tc=%b", n, Q, Qb, tc, exp_q[n], exp_tc[n]);
            end
        end
        en = 1'b0;
        tick();
        total++;
        if (Q !== exp_q[1] || Qb !== ~exp_q[1] || tc !== 1'b0) begin
            bad++;
            $display("FAIL en_gap_hold Q=%h Qb=%h tc=%b want Q=%h tc=0", Q, Qb, tc, exp_q[1]);
        end
        en = 1'b1;
    endtask

    task automatic test_shift();
        logic [7:0] exp_q [3];
        logic       sins  [3];
        exp_q[0] = 8'h03; exp_q[1] = 8'h06; exp_q[2] = 8'h0D;
        sins[0] = 1'b1; sins[1] = 1'b0; sins[2] = 1'b1;
        mode = 2'd1; d = 8'h81;
        tick();
        mode = 2'd3;
        for (int n = 0; n < 3; n++) begin
            sin = sins[n];
            tick();
            total++;
            if (Q !== exp_q[n] || Qb !== ~exp_q[n] || tc !== 1'b0) begin
                bad++;
                $display("FAIL shift n=%0d Q=%h Qb=%h tc=%b want Q=%h tc=0", n, Q, Qb, tc, exp_q[n]);
            end
        end
    endtask

    task automatic test_async_reset_mid_count();
        mode = 2'd1; d = 8'h10;
        tick();
        mode = 2'd2; dir = 1'b1;
        tick();
        tick();
        total++;
        if (Q !== 8'h12) begin
            bad++;
            $display("FAIL midcount_pre Q=%h want 12", Q);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (Q !== RST_VAL || Qb !== ~RST_VAL || tc !== 1'b0) begin
            bad++;
            $display("FAIL midcount_async Q=%h Qb=%h tc=%b want a5/5a/0", Q, Qb, tc);
        end
        #1 rst = 1'b0;
        m_q = RST_VAL; m_tc = 1'b0;
        tick();
        total++;
        if (Q !== 8'hA6 || Qb !== 8'h59 || tc !== 1'b0) begin
            bad++;
            $display("FAIL midcount_restart Q=%h Qb=%h tc=%b want a6/59/0", Q, Qb, tc);
        end
    endtask

    task automatic test_back_to_back();
        int tc_seen;
        int tc_want;
        tc_seen = 0;
        tc_want = 0;
        mode = 2'd1; d = 8'hFD;
        tick();
        mode = 2'd2; dir = 1'b1;
        for (int n = 0; n < 260; n++) begin
            tick();
            if (tc === 1'b1) tc_seen++;
            if (m_tc) tc_want++;
            total++;
            if (Q !== m_q || Qb !== ~m_q || tc !== m_tc) begin
                bad++;
                $display("FAIL back_to_back n=%0d Q=%h Qb=%h tc=%b want Q=%h tc=%b", n, Q, Qb, tc, m_q, m_tc);
            end
        end
        total++;
        if (tc_seen != tc_want) begin
            bad++;
            $display("FAIL back_to_back_tc_count got=%0d want=%0d", tc_seen, tc_want);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en   = ($urandom_range(0, 7) != 0);
            mode = 2'($urandom);
            j    = 8'($urandom);
            k    = 8'($urandom);
            d    = 8'($urandom);
            dir  = 1'($urandom);
            sin  = 1'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #2 rst = 1'b1;
                #1;
                total++;
                if (Q !== RST_VAL || Qb !== ~RST_VAL || tc !== 1'b0) begin
                    bad++;
                    $display("FAIL random_reset n=%0d Q=%h Qb=%h tc=%b want a5/5a/0", n, Q, Qb, tc);
                end
                #1 rst = 1'b0;
                m_q = RST_VAL; m_tc = 1'b0;
            end
            tick();
            total++;
            if (Q !== m_q || Qb !== ~m_q || tc !== m_tc) begin
                bad++;
                $display("FAIL random n=%0d mode=%0d en=%b Q=%h Qb=%h tc=%b want Q=%h tc=%b",
                         n, mode, en, Q, Qb, tc, m_q, m_tc);
            end
        end
    endtask

    initial begin
        m_q  = RST_VAL;
        m_tc = 1'b0;
        test_reset();
        test_jk();
        test_count_up();
        test_count_down_en_gap();
        test_shift();
        test_async_reset_mid_count();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
